xadc_drp_scheduler: RTL and testbench

- Sequences XADC DRP reads across up to NUM_CH auxiliary channels.
- Each XADC end-of-conversion starts one scan. The scan issues one DRP read per enabled channel in ascending index order and returns each result tagged with its channel index.
- Sits between the xadc_wiz_0 DRP port and the downstream averaging/scaling logic, replacing the fixed single-channel den=eoc tie-off.

---
 rtl/xadc_sched_pkg.sv | 10 +
 rtl/xadc_sched_avg.sv | 35 +++
 rtl/xadc_drp_scheduler.sv | 120 ++++++++++++
 tb/tb_xadc_drp_scheduler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/xadc_sched_pkg.sv
// xadc_sched_pkg: shared FSM states, DRP widths and default XADC aux channel addresses.
package xadc_sched_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    localparam int DRP_ADDR_W = 7;
    localparam int DRP_DATA_W = 16;
    localparam logic [DRP_ADDR_W-1:0] VAUX15 = 7'h1f;
    localparam logic [DRP_ADDR_W-1:0] VAUX14 = 7'h1e;
    localparam logic [DRP_ADDR_W-1:0] VAUX7 = 7'h17;
    localparam logic [DRP_ADDR_W-1:0] VAUX6 = 7'h16;
endpackage

// File: rtl/xadc_sched_avg.sv
// xadc_sched_avg: per-slot accumulators; emits the truncated mean of every 2^AVG_POW reads of a slot.
module xadc_sched_avg
    import xadc_sched_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int AVG_POW = 4,
    parameter int CH_W = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_valid,
    input  logic [CH_W-1:0]       rd_slot,
    input  logic [DRP_DATA_W-1:0] rd_data,
    output logic                  out_valid,
    output logic [DRP_DATA_W-1:0] out_data
);
    localparam int ACC_W = DRP_DATA_W + AVG_POW;
    logic [ACC_W-1:0] acc [NUM_CH];
    logic [AVG_POW-1:0] cnt [NUM_CH];
    logic [ACC_W-1:0] sum;
    assign sum = acc[rd_slot] + ACC_W'(rd_data);
    assign out_valid = rd_valid && &cnt[rd_slot];
    assign out_data = sum[AVG_POW +: DRP_DATA_W];
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
        end else if (rd_valid) begin
            acc[rd_slot] <= out_valid ? '0 : sum;
            cnt[rd_slot] <= cnt[rd_slot] + AVG_POW'(1);
        end
    end
endmodule

// File: rtl/xadc_drp_scheduler.sv
// xadc_drp_scheduler: on each XADC eoc, reads every enabled aux channel over DRP in slot order.
// Define XADC_SCHED_AVG_EN to emit 2^AVG_POW-sample averages per slot instead of raw reads.
module xadc_drp_scheduler
    import xadc_sched_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter logic [NUM_CH*DRP_ADDR_W-1:0] CH_ADDRS = {VAUX15, VAUX14, VAUX7, VAUX6},
    parameter int TIMEOUT_CYC = 64,
    parameter int AVG_POW = 4,
    localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  eoc_in,
    input  logic [NUM_CH-1:0]     ch_enable,
    input  logic                  err_clr,
    output logic                  den_out,
    output logic                  dwe_out,
    output logic [DRP_ADDR_W-1:0] daddr_out,
    input  logic                  drdy_in,
    input  logic [DRP_DATA_W-1:0] do_in,
    output logic                  sample_valid,
    output logic [DRP_DATA_W-1:0] sample_data,
    output logic [CH_W-1:0]       sample_ch,
    output logic                  busy,
    output logic                  timeout_err,
    output logic                  overrun_err
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    if (NUM_CH < 1 || NUM_CH > 8 || TIMEOUT_CYC < 2 || AVG_POW < 1) begin : g_bad_param
        $error("xadc_drp_scheduler: parameter out of range");
    end
    state_t state, state_n;
    logic eoc_q, eoc_edge, pending, start, rd_done, expire, emit;
    logic [NUM_CH-1:0] scan_mask;
    logic [CH_W-1:0] slot, slot_n, first_slot, next_slot;
    logic first_ok, next_ok;
    logic [TW-1:0] timer;
    logic [DRP_DATA_W-1:0] emit_data;
    assign dwe_out = 1'b0;
    assign eoc_edge = eoc_in & ~eoc_q;
    assign start = state == IDLE && (eoc_edge || pending);
    assign rd_done = state == WAIT && drdy_in;
    // Abandon the read on the cycle the timer would count down to zero, so ISSUE-to-ISSUE spans TIMEOUT_CYC.
    assign expire = state == WAIT && !drdy_in && timer == TW'(1);
`ifdef XADC_SCHED_AVG_EN
    xadc_sched_avg #(.NUM_CH(NUM_CH), .AVG_POW(AVG_POW), .CH_W(CH_W)) u_avg (
        .clk(clk), .reset(reset), .rd_valid(rd_done), .rd_slot(slot), .rd_data(do_in),
        .out_valid(emit), .out_data(emit_data)
    );
`else
    assign emit = rd_done;
    assign emit_data = do_in;
`endif
    always_comb begin
        first_slot = '0;
        first_ok = 1'b0;
        next_slot = '0;
        next_ok = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_enable[i]) begin
                first_slot = CH_W'(i);
                first_ok = 1'b1;
            end
            if (scan_mask[i] && i > int'(slot)) begin
                next_slot = CH_W'(i);
                next_ok = 1'b1;
            end
        end
    end
    always_comb begin
        state_n = state;
        slot_n = slot;
        case (state)
            IDLE: if (start && first_ok) begin
                state_n = ISSUE;
                slot_n = first_slot;
            end
            ISSUE: state_n = WAIT;
            WAIT: if (rd_done || expire) begin
                state_n = next_ok ? ISSUE : IDLE;
                slot_n = next_ok ? next_slot : slot;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            slot <= '0;
            eoc_q <= 1'b0;
            scan_mask <= '0;
            pending <= 1'b0;
            timer <= '0;
            den_out <= 1'b0;
            daddr_out <= '0;
            busy <= 1'b0;
            sample_valid <= 1'b0;
            sample_data <= '0;
            sample_ch <= '0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            state <= state_n;
            slot <= slot_n;
            eoc_q <= eoc_in;
            scan_mask <= start ? ch_enable : scan_mask;
            pending <= start ? 1'b0 : (eoc_edge && state != IDLE) ? 1'b1 : pending;
            timer <= state == ISSUE ? TW'(TIMEOUT_CYC - 1) : state == WAIT ? timer - TW'(1) : timer;
            den_out <= state_n == ISSUE;
            daddr_out <= state_n == ISSUE ? CH_ADDRS[int'(slot_n) * DRP_ADDR_W +: DRP_ADDR_W] : daddr_out;
            busy <= state_n != IDLE;
            sample_valid <= emit;
            sample_data <= emit ? emit_data : sample_data;
            sample_ch <= emit ? slot : sample_ch;
            timeout_err <= expire ? 1'b1 : err_clr ? 1'b0 : timeout_err;
            overrun_err <= (eoc_edge && state != IDLE && pending) ? 1'b1 : err_clr ? 1'b0 : overrun_err;
        end
    end
endmodule

// File: tb/tb_xadc_drp_scheduler.sv
// tb_xadc_drp_scheduler: directed scans against a DRP responder that answers 3 cycles after den.
module tb_xadc_drp_scheduler;
    import xadc_sched_pkg::*;
    typedef struct {int cyc; logic [6:0] addr; logic [1:0] ch; logic [15:0] data;} ev_t;
    logic clk = 1'b0, reset = 1'b0, eoc_in = 1'b0, err_clr = 1'b0;
    logic [3:0] ch_enable = '0;
    logic den_out, dwe_out, drdy_in, sample_valid, busy, timeout_err, overrun_err;
    logic [6:0] daddr_out;
    logic [15:0] do_in, sample_data;
    logic [1:0] sample_ch;
    logic model_en = 1'b1, model_drdy = 1'b0, man_drdy = 1'b0, seq_mode = 1'b0;
    logic [15:0] model_data = '0, man_data = '0, seq = '0;
    logic [6:0] hang_addr = 7'h00, cur_addr = 7'h00;
    int dly = 0, cyc = 0, n_chk = 0, n_pass = 0, busy_cnt = 0;
    ev_t den_q[$], smp_q[$];

    assign drdy_in = man_drdy | model_drdy;
    assign do_in = man_drdy ? man_data : model_data;

    xadc_drp_scheduler #(
        .NUM_CH(4), .CH_ADDRS({7'h16, 7'h17, 7'h1e, 7'h1f}), .TIMEOUT_CYC(64), .AVG_POW(2)
    ) dut (
        .clk(clk), .reset(reset), .eoc_in(eoc_in), .ch_enable(ch_enable), .err_clr(err_clr),
        .den_out(den_out), .dwe_out(dwe_out), .daddr_out(daddr_out), .drdy_in(drdy_in),
        .do_in(do_in), .sample_valid(sample_valid), .sample_data(sample_data),
        .sample_ch(sample_ch), .busy(busy), .timeout_err(timeout_err), .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] resp(logic [6:0] a);
        return a == 7'h1f ? 16'h1000 : a == 7'h1e ? 16'h1001 : a == 7'h17 ? 16'h1002 : 16'h1003;
    endfunction

    // Monitor and DRP responder share the falling edge, well away from the DUT's sampling edge.
    always @(negedge clk) begin
        if (den_out) den_q.push_back('{cyc, daddr_out, 2'd0, 16'd0});
        if (sample_valid) smp_q.push_back('{cyc, 7'd0, sample_ch, sample_data});
        if (busy) busy_cnt++;
        model_drdy = 1'b0;
        if (den_out && model_en && daddr_out != hang_addr) begin
            dly = 3;
            cur_addr = daddr_out;
        end else if (den_out || !model_en) begin
            dly = 0;
        end else if (dly > 0) begin
            dly--;
            if (dly == 0) begin
                model_drdy = 1'b1;
                model_data = seq_mode ? 16'd10 + seq : resp(cur_addr);
                seq++;
            end
        end
    end

    function automatic ev_t den_at(int i);
        ev_t e = '{-1, '1, '1, '1};
        if (i < den_q.size()) e = den_q[i];
        return e;
    endfunction

    function automatic ev_t smp_at(int i);
        ev_t e = '{-1, '1, '1, '1};
        if (i < smp_q.size()) e = smp_q[i];
        return e;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        den_q.delete();
        smp_q.delete();
        busy_cnt = 0;
    endtask

    task automatic pulse_eoc(output int t);
        eoc_in = 1'b1;
        t = cyc;
        step(1);
        eoc_in = 1'b0;
    endtask

    task automatic check_quiet(string tag);
        check({tag, "_den"}, den_out, 0);
        check({tag, "_dwe"}, dwe_out, 0);
        check({tag, "_daddr"}, daddr_out, 0);
        check({tag, "_sv"}, sample_valid, 0);
        check({tag, "_sdata"}, sample_data, 0);
        check({tag, "_sch"}, sample_ch, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_tmo"}, timeout_err, 0);
        check({tag, "_ovr"}, overrun_err, 0);
    endtask

    initial begin
        int t0;
        logic [6:0] exp_a[4] = '{7'h1f, 7'h1e, 7'h17, 7'h16};
        step(3);
        check_quiet("rst");
        reset = 1'b1;
        step(2);
`ifdef XADC_SCHED_AVG_EN
        ch_enable = 4'b0001;
        seq_mode = 1'b1;
        seq = '0;
        clear_logs();
        repeat (4) begin
            pulse_eoc(t0);
            step(12);
        end
        check("avg_nden", den_q.size(), 4);
        check("avg_nsmp", smp_q.size(), 1);
        check("avg_data", smp_at(0).data, 16'd11);
        check("avg_ch", smp_at(0).ch, 0);
        check("avg_cyc", smp_at(0).cyc, t0 + 5);
`else
        ch_enable = 4'b1111;
        clear_logs();
        pulse_eoc(t0);
        step(25);
        check("s1_nden", den_q.size(), 4);
        check("s1_nsmp", smp_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("s1_addr", den_at(i).addr, exp_a[i]);
            check("s1_dcyc", den_at(i).cyc, t0 + 1 + 4 * i);
            check("s1_sch", smp_at(i).ch, i);
            check("s1_sdata", smp_at(i).data, 16'h1000 + i);
            check("s1_scyc", smp_at(i).cyc, t0 + 5 + 4 * i);
        end
        check("s1_busy_cnt", busy_cnt, 16);
        check("s1_busy", busy, 0);
        check("s1_tmo", timeout_err, 0);

        ch_enable = 4'b0101;
        clear_logs();
        pulse_eoc(t0);
        step(20);
        check("s2_nden", den_q.size(), 2);
        check("s2_addr1", den_at(1).addr, 7'h17);
        check("s2_nsmp", smp_q.size(), 2);
        check("s2_ch1", smp_at(1).ch, 2);
        check("s2_data1", smp_at(1).data, 16'h1002);

        ch_enable = 4'b0000;
        clear_logs();
        pulse_eoc(t0);
        step(10);
        check("s3_nden", den_q.size(), 0);
        check("s3_busy_cnt", busy_cnt, 0);

        ch_enable = 4'b1111;
        hang_addr = 7'h1e;
        clear_logs();
        pulse_eoc(t0);
        step(100);
        check("to_nden", den_q.size(), 4);
        check("to_d1cyc", den_at(1).cyc, t0 + 5);
        check("to_d2cyc", den_at(2).cyc, t0 + 69);
        check("to_d2addr", den_at(2).addr, 7'h17);
        check("to_nsmp", smp_q.size(), 3);
        check("to_ch1", smp_at(1).ch, 2);
        check("to_data1", smp_at(1).data, 16'h1002);
        check("to_err", timeout_err, 1);
        check("to_ovr", overrun_err, 0);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        check("to_clr", timeout_err, 0);
        hang_addr = 7'h00;

        ch_enable = 4'b0011;
        clear_logs();
        pulse_eoc(t0);
        step(1);
        eoc_in = 1'b1;
        step(1);
        eoc_in = 1'b0;
        check("ov_first", overrun_err, 0);
        step(1);
        eoc_in = 1'b1;
        step(1);
        eoc_in = 1'b0;
        check("ov_second", overrun_err, 1);
        step(30);
        check("ov_nden", den_q.size(), 4);
        check("ov_d2cyc", den_at(2).cyc, t0 + 10);
        check("ov_d2addr", den_at(2).addr, 7'h1f);
        check("ov_d3cyc", den_at(3).cyc, t0 + 14);
        check("ov_nsmp", smp_q.size(), 4);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        check("ov_clr", overrun_err, 0);

        ch_enable = 4'b1111;
        model_en = 1'b0;
        clear_logs();
        pulse_eoc(t0);
        step(1);
        reset = 1'b0;
        step(2);
        reset = 1'b1;
        man_data = 16'hdead;
        man_drdy = 1'b1;
        step(1);
        man_drdy = 1'b0;
        step(5);
        check_quiet("rw");
        check("rw_nden", den_q.size(), 1);
        check("rw_nsmp", smp_q.size(), 0);
        model_en = 1'b1;
        clear_logs();
        pulse_eoc(t0);
        step(25);
        check("rw_re_nden", den_q.size(), 4);
        check("rw_re_addr0", den_at(0).addr, 7'h1f);
        check("rw_re_cyc0", den_at(0).cyc, t0 + 1);
        check("rw_re_nsmp", smp_q.size(), 4);
        check("rw_re_data0", smp_at(0).data, 16'h1000);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
